// File: rtl/gin_pe_unpack_fifo.sv
// rtl/gin_pe_unpack_fifo.sv - GIN word receive buffer that unpacks words into PE operands
//
// Purpose: stores up to DEPTH DATA_WIDTH-bit words taken from an X_Bus column
// and hands them to one PE as WORD_WIDTH-bit operands, lane 0 (LSBs) first.
//
// Ports:
//   link_clk   clock, rising edge
//   reset      asynchronous active-low reset
//   data_in    GIN word from the X_Bus column
//   enable_in  data_in is valid this cycle
//   ready_out  buffer has room (registered state only; drives column ready_in)
//   pe_data    current operand, 0 while empty
//   pe_valid   pe_data is valid
//   pe_ready   PE consumes pe_data this cycle
//   occupancy  stored words, including a partially consumed head
//   overflow   sticky: a word arrived while full and was dropped
module gin_pe_unpack_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                       link_clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       enable_in,
  output logic                       ready_out,
  output logic [WORD_WIDTH-1:0]      pe_data,
  output logic                       pe_valid,
  input  logic                       pe_ready,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       overflow
);

  localparam int LANES = DATA_WIDTH / WORD_WIDTH;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic [LW-1:0] lane_idx_q, lane_idx_d;
  logic          overflow_q, overflow_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic last_lane;
  logic release_head;
  logic [DATA_WIDTH-1:0] head_word;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign push         = enable_in && !full;
  assign pop          = !empty && pe_ready;
  assign last_lane    = (lane_idx_q == LW'(LANES - 1));
  assign release_head = pop && last_lane;
  assign head_word    = mem_q[rd_ptr_q];

  assign ready_out = !full;
  assign pe_valid  = !empty;
  assign occupancy = count_q;
  assign overflow  = overflow_q;

  always_comb begin
    pe_data = '0;
    if (!empty) begin
      pe_data = head_word[int'(lane_idx_q)*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    lane_idx_d = lane_idx_q;
    overflow_d = overflow_q;

    if (push) begin
      // DEPTH is a power of two, so the pointer wraps on natural overflow.
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (enable_in && full) begin
      overflow_d = 1'b1;
    end

    if (pop) begin
      if (last_lane) begin
        lane_idx_d = '0;
        rd_ptr_d   = rd_ptr_q + PW'(1);
      end else begin
        lane_idx_d = lane_idx_q + LW'(1);
      end
    end

    // Only a final-lane pop frees an entry; push and release together cancel.
    if (push && !release_head) begin
      count_d = count_q + CW'(1);
    end else if (!push && release_head) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge link_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lane_idx_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      lane_idx_q <= lane_idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge link_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_gin_pe_unpack_fifo.sv
// tb/tb_gin_pe_unpack_fifo.sv - directed self-checking bench for gin_pe_unpack_fifo
module tb_gin_pe_unpack_fifo;

  logic        link_clk;
  logic        reset;
  logic [63:0] data_in;
  logic        enable_in;
  logic        ready_out;
  logic [15:0] pe_data;
  logic        pe_valid;
  logic        pe_ready;
  logic [2:0]  occupancy;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [63:0] fill_w [4];

  gin_pe_unpack_fifo #(
    .DATA_WIDTH(64),
    .WORD_WIDTH(16),
    .DEPTH     (4)
  ) dut (
    .link_clk (link_clk),
    .reset    (reset),
    .data_in  (data_in),
    .enable_in(enable_in),
    .ready_out(ready_out),
    .pe_data  (pe_data),
    .pe_valid (pe_valid),
    .pe_ready (pe_ready),
    .occupancy(occupancy),
    .overflow (overflow)
  );

  initial link_clk = 1'b0;
  always #5 link_clk = ~link_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge link_clk);
    #1;
  endtask

  initial begin
    int nxt;
    int exp_op;
    int cyc;

    fill_w[0] = 64'hA003_A002_A001_A000;
    fill_w[1] = 64'hB003_B002_B001_B000;
    fill_w[2] = 64'hC003_C002_C001_C000;
    fill_w[3] = 64'hD003_D002_D001_D000;

    reset     = 1'b0;
    data_in   = '0;
    enable_in = 1'b0;
    pe_ready  = 1'b0;

    // Reset / idle
    step();
    step();
    chk("rst_hold_ready", ready_out, 1);
    chk("rst_hold_valid", pe_valid, 0);
    reset = 1'b1;
    step();
    chk("idle_ready", ready_out, 1);
    chk("idle_valid", pe_valid, 0);
    chk("idle_data", pe_data, 0);
    chk("idle_occ", occupancy, 0);
    chk("idle_ovf", overflow, 0);
    for (int i = 0; i < 5; i++) begin
      pe_ready = ~pe_ready;
      step();
      chk("idle_toggle_valid", pe_valid, 0);
      chk("idle_toggle_occ", occupancy, 0);
      chk("idle_toggle_data", pe_data, 0);
    end

    // Single word, PE always ready
    pe_ready  = 1'b1;
    data_in   = 64'h0004_0003_0002_0001;
    enable_in = 1'b1;
    step();
    enable_in = 1'b0;
    chk("single_valid", pe_valid, 1);
    chk("single_occ", occupancy, 1);
    chk("single_lane0", pe_data, 16'h0001);
    step();
    chk("single_lane1", pe_data, 16'h0002);
    step();
    chk("single_lane2", pe_data, 16'h0003);
    step();
    chk("single_lane3", pe_data, 16'h0004);
    step();
    chk("single_done_valid", pe_valid, 0);
    chk("single_done_occ", occupancy, 0);

    // Fill and stall
    pe_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in   = fill_w[i];
      enable_in = 1'b1;
      step();
    end
    enable_in = 1'b0;
    chk("fill_occ", occupancy, 4);
    chk("fill_ready", ready_out, 0);
    chk("fill_ovf_clear", overflow, 0);
    data_in   = 64'hEEEE_EEEE_EEEE_EEEE;
    enable_in = 1'b1;
    step();
    enable_in = 1'b0;
    data_in   = '0;
    chk("ovf_set", overflow, 1);
    chk("ovf_occ", occupancy, 4);
    chk("ovf_head", pe_data, 16'hA000);

    // Full release: ready stays low through the final-lane pop cycle
    pe_ready = 1'b1;
    step();
    chk("rel_lane1", pe_data, 16'hA001);
    step();
    chk("rel_lane2", pe_data, 16'hA002);
    step();
    chk("rel_lane3", pe_data, 16'hA003);
    chk("rel_ready_during_pop", ready_out, 0);
    chk("rel_occ_during_pop", occupancy, 4);
    step();
    chk("rel_ready_after", ready_out, 1);
    chk("rel_occ_after", occupancy, 3);
    for (int i = 1; i < 4; i++) begin
      for (int l = 0; l < 4; l++) begin
        chk("drain_data", pe_data, fill_w[i][l*16 +: 16]);
        step();
      end
    end
    chk("drain_valid", pe_valid, 0);
    chk("drain_occ", occupancy, 0);
    chk("drain_ovf_sticky", overflow, 1);

    // Clear the sticky overflow before streaming
    reset = 1'b0;
    #1;
    reset = 1'b1;
    step();
    chk("ovf_cleared", overflow, 0);

    // Streaming wrap: 12 words, producer honours ready_out
    nxt    = 0;
    exp_op = 0;
    cyc    = 0;
    pe_ready = 1'b1;
    while (exp_op < 48 && cyc < 300) begin
      if (pe_valid) begin
        chk("stream_data", pe_data, exp_op);
        exp_op++;
      end
      chk("stream_occ_le4", (occupancy <= 3'd4), 1);
      if (nxt < 12 && ready_out) begin
        enable_in = 1'b1;
        data_in   = {16'(nxt*4+3), 16'(nxt*4+2), 16'(nxt*4+1), 16'(nxt*4)};
        nxt++;
      end else begin
        enable_in = 1'b0;
      end
      step();
      cyc++;
    end
    enable_in = 1'b0;
    chk("stream_total", exp_op, 48);
    chk("stream_words_sent", nxt, 12);
    chk("stream_ovf", overflow, 0);
    chk("stream_end_valid", pe_valid, 0);

    // Mid-stream asynchronous reset
    pe_ready  = 1'b0;
    data_in   = 64'h5003_5002_5001_5000;
    enable_in = 1'b1;
    step();
    data_in   = 64'h5103_5102_5101_5100;
    step();
    enable_in = 1'b0;
    pe_ready  = 1'b1;
    step();
    pe_ready  = 1'b0;
    chk("mid_lane1", pe_data, 16'h5001);
    chk("mid_occ", occupancy, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", pe_valid, 0);
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_data", pe_data, 0);
    chk("mid_rst_ready", ready_out, 1);
    #1;
    reset = 1'b1;
    step();
    data_in   = 64'h6003_6002_6001_6000;
    enable_in = 1'b1;
    step();
    enable_in = 1'b0;
    chk("post_rst_valid", pe_valid, 1);
    chk("post_rst_occ", occupancy, 1);
    chk("post_rst_lane0", pe_data, 16'h6000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
